varre_pontos: RTL
=================

VARRE_PONTOS -- requirements
Module: varre_pontos

Interface
REQ-001 SHALL have parameter LARGURA, default 800, horizontal pixel count.
REQ-002 SHALL have parameter ALTURA, default 600, vertical pixel count.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, begin one full-frame scan when idle.
REQ-006 SHALL have ports x and y, output, 11 each, point driven to the downstream point-classifier stage.
REQ-007 SHALL have ports pronto and cor, input, 1 each, classifier result-ready flag and inside-triangle colour bit.
REQ-008 SHALL have ports pix_valid (output, 1), pix_ready (input, 1), pix_x and pix_y (output, 11 each), and pix_cor (output, 1), forming the classified-pixel stream.
REQ-009 SHALL have ports busy (output, 1, scan in progress) and done (output, 1, one-cycle end-of-frame pulse).

Function
REQ-010 SHALL implement states OCIOSO, APRESENTA, ESPERA, EMITE and FIM.
REQ-011 OCIOSO: with start=1, SHALL load x=0 and y=0 and go to APRESENTA; start SHALL be ignored in every other state.
REQ-012 APRESENTA SHALL last exactly one cycle with pronto ignored, so the classifier can clear its previous result, then go to ESPERA.
REQ-013 ESPERA SHALL hold x and y stable; on the first cycle with pronto=1 it SHALL capture cor into pix_cor, copy x/y into pix_x/pix_y, and go to EMITE.
REQ-014 EMITE SHALL assert pix_valid, holding pix_x, pix_y and pix_cor stable until a cycle with pix_valid=1 and pix_ready=1.
REQ-015 On that handshake, the block SHALL advance the point in raster order and go to APRESENTA. Raster order is x+1; at x=LARGURA-1, x wraps to 0 and y increments.
REQ-016 A handshake at x=LARGURA-1 and y=ALTURA-1 SHALL go to FIM instead of advancing.
REQ-017 FIM SHALL pulse done for exactly one cycle, then return to OCIOSO, leaving x/y at the last point.
REQ-018 busy SHALL be 1 in every state except OCIOSO.
REQ-019 pix_valid SHALL be 1 only in EMITE and SHALL never drop before its handshake.
REQ-020 x and y SHALL change only when leaving OCIOSO or on a handshake in EMITE.
REQ-021 Counters SHALL be 11 bits unsigned; parameters above 2047 are unsupported.
REQ-022 A pixel SHALL take at least 3 cycles: APRESENTA, ESPERA and EMITE.
REQ-023 If pronto is already 1 on entry to ESPERA, the block SHALL capture on that first ESPERA cycle.

Reset
REQ-024 rst_n=0 SHALL force, immediately and regardless of clk, state to OCIOSO and x, y, pix_x, pix_y, pix_cor, pix_valid, busy and done to 0.
REQ-025 Reset mid-scan SHALL abandon the frame; no done pulse SHALL be produced for it.
REQ-026 After rst_n rises, the block SHALL wait in OCIOSO for a new start.

Configuration
REQ-027 With macro VARRE_CONTAGEM_EN defined, the block SHALL add output cont_cor (20 bits). cont_cor SHALL clear to 0 on reset and on leaving OCIOSO, increment on each EMITE handshake with pix_cor=1, and hold its value after FIM.
REQ-028 Without VARRE_CONTAGEM_EN, cont_cor SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-029 LARGURA=4, ALTURA=2, pix_ready=1, pronto tied 1, cor tied 0 -> 8 pixels in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1); done pulses once; a pixel every 3 cycles.
REQ-030 Model classifier with triangle (10,10),(200,100),(300,300) over LARGURA=16, ALTURA=16; pronto asserted 2 cycles after each new point -> pix_cor matches the reference sign test for all 256 points.
REQ-031 Hold pix_ready=0 for 5 cycles during pixel (2,0) -> pix_valid stays 1, pix_x=2 and pix_y=0 stable, x/y unchanged; advance occurs only after pix_ready=1.
REQ-032 Assert rst_n=0 mid-frame at pixel (1,1) -> outputs go to 0 asynchronously; no done pulse; a new start restarts at (0,0).
REQ-033 Pulse start while busy -> ignored; scan continues unchanged.
REQ-034 With VARRE_CONTAGEM_EN defined, LARGURA=4, ALTURA=2, cor tied 1 -> cont_cor=8 after done; a second start clears it to 0 first.

Source files
------------

// File: rtl/varre_pontos.sv
// Raster point scanner: walks every (x,y) of a LARGURA x ALTURA frame, presents it to a
// point classifier and streams the classified pixel out. Optional macro VARRE_CONTAGEM_EN adds cont_cor.
module varre_pontos #(
    parameter int LARGURA = 800,
    parameter int ALTURA  = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [10:0] x,
    output logic [10:0] y,
    input  logic        pronto,
    input  logic        cor,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_cor,
`ifdef VARRE_CONTAGEM_EN
    output logic [19:0] cont_cor,
`endif
    output logic        busy,
    output logic        done
);

    localparam logic [10:0] X_ULT = 11'(LARGURA - 1);
    localparam logic [10:0] Y_ULT = 11'(ALTURA - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        APRESENTA,
        ESPERA,
        EMITE,
        FIM
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [10:0] pix_y_q, pix_y_d;
    logic        pix_cor_q, pix_cor_d;
    logic        handshake;
    logic        inicia;

    assign handshake = (estado_q == EMITE) && pix_ready;
    assign inicia    = (estado_q == OCIOSO) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            x_q       <= '0;
            y_q       <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            pix_cor_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            pix_cor_q <= pix_cor_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        pix_cor_d = pix_cor_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    x_d      = '0;
                    y_d      = '0;
                    estado_d = APRESENTA;
                end
            end
            // One dead cycle so the classifier can drop the result of the previous point.
            APRESENTA: estado_d = ESPERA;
            ESPERA: begin
                if (pronto) begin
                    pix_x_d   = x_q;
                    pix_y_d   = y_q;
                    pix_cor_d = cor;
                    estado_d  = EMITE;
                end
            end
            EMITE: begin
                if (pix_ready) begin
                    if (x_q == X_ULT) begin
                        if (y_q == Y_ULT) begin
                            estado_d = FIM;
                        end else begin
                            x_d      = '0;
                            y_d      = y_q + 11'd1;
                            estado_d = APRESENTA;
                        end
                    end else begin
                        x_d      = x_q + 11'd1;
                        estado_d = APRESENTA;
                    end
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Status outputs decode the state directly so reset clears them without waiting for clk.
    assign busy      = (estado_q != OCIOSO);
    assign done      = (estado_q == FIM);
    assign pix_valid = (estado_q == EMITE);
    assign x         = x_q;
    assign y         = y_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_cor   = pix_cor_q;

`ifdef VARRE_CONTAGEM_EN
    logic [19:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (inicia) begin
            cont_d = '0;
        end else if (handshake && pix_cor_q) begin
            cont_d = cont_q + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign cont_cor = cont_q;
`else
    logic nao_usado;
    assign nao_usado = inicia & handshake;
`endif

endmodule
